// File: rtl/alu_issue_sched_pkg.sv
// Shared types and constants for the ALU issue scheduler.
package alu_issue_sched_pkg;

    localparam int unsigned NUM_SHARED_ALU = 2;
    // Owner index is stored at a fixed maximum width so the record type is parameter-independent.
    localparam int unsigned MAX_IDX_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] idx;
    } alu_owner_t;

endpackage

// File: rtl/alu_issue_sched_rr_find_first.sv
// Circular first-set finder: scans i_req & ~i_mask starting at i_start.
module rr_find_first #(
    parameter int unsigned N = 8,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_start,
    input  logic [N-1:0] i_mask,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    logic [N-1:0] w_cand;
    logic [W-1:0] w_pos;

    assign w_cand = i_req & ~i_mask;

    // Walk the scan backwards so the last hit written is the first in scan order.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_pos = i_start + W'(i);
            if (w_cand[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/alu_issue_sched.sv
// Round-robin issue of ready RS entries onto a shared pool of ALUs, with owner tracking.
// Optional feature: define ALU_ISSUE_BYPASS_EN to let a completing ALU accept a new op the same cycle.
module alu_issue_sched
    import alu_issue_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned NUM_ALU = NUM_SHARED_ALU,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_ALU-1:0]       alu_busy_i,
    input  logic [NUM_ALU-1:0]       alu_done_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_ALU-1:0]       alu_start_o,
    output logic [NUM_ALU*IDX_W-1:0] alu_sel_o,
    output logic [NUM_REQ-1:0]       inflight_o,
    output logic [NUM_REQ-1:0]       done_o
);

    localparam int unsigned SLOT_W = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;

    alu_owner_t                        r_owner [NUM_ALU];
    logic [IDX_W-1:0]                  r_rr_ptr;
    logic [NUM_REQ-1:0]                r_done;

    logic                              w_active;
    logic [NUM_REQ-1:0]                w_inflight;
    logic [NUM_REQ-1:0]                w_elig;
    logic [NUM_ALU-1:0]                w_free;
    logic [NUM_ALU:0][NUM_REQ-1:0]     w_mask;
    logic [NUM_ALU-1:0]                w_found;
    logic [NUM_ALU-1:0][IDX_W-1:0]     w_idx;
    logic [NUM_REQ-1:0]                w_gnt;
    logic [NUM_ALU-1:0]                w_start;
    logic [NUM_ALU*IDX_W-1:0]          w_sel;
    logic [IDX_W-1:0]                  w_last;
    logic                              w_any;
    logic [NUM_REQ-1:0]                w_done_next;

    // Reset is asynchronous, so the combinational issue path is gated by it too.
    assign w_active = rst & ~flush;

    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < NUM_ALU; k++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (r_owner[k].valid && (r_owner[k].idx == MAX_IDX_W'(r)))
                    w_inflight[r] = 1'b1;
            end
        end
    end

    assign w_elig   = req_i & ~w_inflight;
    assign w_mask[0] = '0;

    generate
        for (genvar gi = 0; gi < NUM_ALU; gi++) begin : g_alu
            // Stage gi finds the gi-th eligible entry in scan order.
            rr_find_first #(
                .N (NUM_REQ),
                .W (IDX_W)
            ) u_find (
                .i_req   (w_elig),
                .i_start (r_rr_ptr),
                .i_mask  (w_mask[gi]),
                .o_found (w_found[gi]),
                .o_idx   (w_idx[gi])
            );

            assign w_mask[gi+1] = w_mask[gi] |
                (w_found[gi] ? (NUM_REQ'(1) << w_idx[gi]) : '0);

`ifdef ALU_ISSUE_BYPASS_EN
            assign w_free[gi] = (!r_owner[gi].valid || alu_done_i[gi]) && !alu_busy_i[gi];
`else
            assign w_free[gi] = !r_owner[gi].valid && !alu_busy_i[gi];
`endif
        end
    endgenerate

    // The j-th free ALU (lowest index first) takes the j-th finder result.
    always_comb begin
        logic [SLOT_W-1:0] v_slot;
        w_gnt   = '0;
        w_start = '0;
        w_sel   = '0;
        w_last  = r_rr_ptr;
        w_any   = 1'b0;
        v_slot  = '0;
        for (int k = 0; k < NUM_ALU; k++) begin
            if (w_active && w_free[k] && w_found[v_slot]) begin
                w_gnt[w_idx[v_slot]]        = 1'b1;
                w_start[k]                  = 1'b1;
                w_sel[k*IDX_W +: IDX_W]     = w_idx[v_slot];
                w_last                      = w_idx[v_slot];
                w_any                       = 1'b1;
                v_slot                      = v_slot + SLOT_W'(1);
            end
        end
    end

    always_comb begin
        w_done_next = '0;
        for (int k = 0; k < NUM_ALU; k++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!flush && alu_done_i[k] && r_owner[k].valid &&
                    (r_owner[k].idx == MAX_IDX_W'(r)))
                    w_done_next[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_ALU; k++)
                r_owner[k] <= '0;
            r_rr_ptr <= '0;
            r_done   <= '0;
        end else begin
            r_done <= w_done_next;
            if (flush) begin
                for (int k = 0; k < NUM_ALU; k++)
                    r_owner[k].valid <= 1'b0;
                r_rr_ptr <= '0;
            end else begin
                for (int k = 0; k < NUM_ALU; k++) begin
                    if (w_start[k]) begin
                        r_owner[k].valid <= 1'b1;
                        r_owner[k].idx   <= MAX_IDX_W'(w_sel[k*IDX_W +: IDX_W]);
                    end else if (alu_done_i[k]) begin
                        r_owner[k].valid <= 1'b0;
                    end
                end
                if (w_any)
                    r_rr_ptr <= w_last + IDX_W'(1);
            end
        end
    end

    assign gnt_o       = w_gnt;
    assign alu_start_o = w_start;
    assign alu_sel_o   = w_sel;
    assign inflight_o  = w_inflight;
    assign done_o      = r_done;

endmodule

// File: tb/tb_alu_issue_sched.sv
// Randomized scoreboard bench for alu_issue_sched against a list-based reference model.
module tb_alu_issue_sched;

    localparam int NR = 8;
    localparam int NA = 2;
    localparam int IW = 3;
`ifdef ALU_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic [NR-1:0]  req_i = '0;
    logic [NA-1:0]  alu_busy_i = '0;
    logic [NA-1:0]  alu_done_i = '0;
    logic [NR-1:0]  gnt_o;
    logic [NA-1:0]  alu_start_o;
    logic [NA*IW-1:0] alu_sel_o;
    logic [NR-1:0]  inflight_o;
    logic [NR-1:0]  done_o;

    always #5 clk = ~clk;

    alu_issue_sched #(.NUM_REQ(NR), .NUM_ALU(NA), .IDX_W(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_i       (req_i),
        .alu_busy_i  (alu_busy_i),
        .alu_done_i  (alu_done_i),
        .gnt_o       (gnt_o),
        .alu_start_o (alu_start_o),
        .alu_sel_o   (alu_sel_o),
        .inflight_o  (inflight_o),
        .done_o      (done_o)
    );

    typedef struct packed {
        logic [NR-1:0]    gnt;
        logic [NA-1:0]    start;
        logic [NA*IW-1:0] sel;
        logic [NR-1:0]    infl;
        logic [NR-1:0]    done;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference state: which entry owns each ALU, scan start, pending done pulses.
    bit            m_valid [NA];
    int            m_idx   [NA];
    int            m_ptr;
    logic [NR-1:0] m_done;

    task automatic drive(input logic r, input logic f, input logic [NR-1:0] rq,
                         input logic [NA-1:0] b, input logic [NA-1:0] d);
        exp_t          e;
        int            elig[$];
        int            free[$];
        int            n;
        logic [NR-1:0] nd;
        @(negedge clk);
        rst = r; flush = f; req_i = rq; alu_busy_i = b; alu_done_i = d;
        e = '0;
        if (!r) begin
            for (int k = 0; k < NA; k++) m_valid[k] = 1'b0;
            m_ptr  = 0;
            m_done = '0;
        end else begin
            for (int k = 0; k < NA; k++) if (m_valid[k]) e.infl[m_idx[k]] = 1'b1;
            e.done = m_done;
            for (int i = 0; i < NR; i++) begin
                int x;
                x = (m_ptr + i) % NR;
                if (rq[x] && !e.infl[x]) elig.push_back(x);
            end
            for (int k = 0; k < NA; k++)
                if (!b[k] && (!m_valid[k] || (BYP && d[k]))) free.push_back(k);
            n = (elig.size() < free.size()) ? elig.size() : free.size();
            if (f) n = 0;
            for (int j = 0; j < n; j++) begin
                e.gnt[elig[j]]          = 1'b1;
                e.start[free[j]]        = 1'b1;
                e.sel[free[j]*IW +: IW] = IW'(elig[j]);
            end
            nd = '0;
            if (!f)
                for (int k = 0; k < NA; k++) if (d[k] && m_valid[k]) nd[m_idx[k]] = 1'b1;
            m_done = nd;
            if (f) begin
                for (int k = 0; k < NA; k++) m_valid[k] = 1'b0;
                m_ptr = 0;
            end else begin
                for (int k = 0; k < NA; k++) if (d[k] && !e.start[k]) m_valid[k] = 1'b0;
                for (int j = 0; j < n; j++) begin
                    m_valid[free[j]] = 1'b1;
                    m_idx[free[j]]   = elig[j];
                end
                if (n > 0) m_ptr = (elig[n-1] + 1) % NR;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents a fresh output set, compared against the oldest expectation.
    initial begin
        exp_t me;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                me = sb_q.pop_front();
                cyc++;
                check("gnt",      32'(gnt_o),       32'(me.gnt));
                check("start",    32'(alu_start_o), 32'(me.start));
                check("sel",      32'(alu_sel_o),   32'(me.sel));
                check("inflight", 32'(inflight_o),  32'(me.infl));
                check("done",     32'(done_o),      32'(me.done));
                $display("cyc=%0d rst=%0b fl=%0b req=%h busy=%b adone=%b gnt=%h start=%b sel=%h infl=%h done=%h",
                         cyc, rst, flush, req_i, alu_busy_i, alu_done_i,
                         gnt_o, alu_start_o, alu_sel_o, inflight_o, done_o);
            end
        end
    end

    initial begin
        int wait_cnt;
        // Reset with all requests high, then first grant and round-robin rotation.
        drive(1'b0, 1'b0, 8'hFF, 2'b00, 2'b00);
        drive(1'b0, 1'b0, 8'hFF, 2'b00, 2'b00);
        drive(1'b1, 1'b0, 8'hFF, 2'b00, 2'b00);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'hFF, 2'b00, 2'b11);
        drive(1'b1, 1'b0, 8'hFF, 2'b00, 2'b01);
        // Flush while both ALUs owned and completing.
        drive(1'b1, 1'b1, 8'hFF, 2'b00, 2'b11);
        drive(1'b1, 1'b0, 8'h00, 2'b00, 2'b11);
        drive(1'b1, 1'b0, 8'h00, 2'b00, 2'b00);
        // Busy ALU1: entry 4 on ALU0, then entry 5 on ALU1.
        drive(1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        drive(1'b1, 1'b0, 8'h30, 2'b10, 2'b00);
        drive(1'b1, 1'b0, 8'h30, 2'b00, 2'b00);
        drive(1'b1, 1'b0, 8'h00, 2'b00, 2'b11);
        drive(1'b1, 1'b0, 8'h00, 2'b00, 2'b00);
        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            logic [NA-1:0] b;
            logic [NA-1:0] d;
            for (int k = 0; k < NA; k++) begin
                b[k] = ($urandom_range(0, 3) == 0);
                d[k] = ($urandom_range(0, 1) == 0);
            end
            drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) == 0),
                  NR'($urandom), b, d);
        end
        drive(1'b1, 1'b0, 8'h00, 2'b00, 2'b00);
        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        #3;
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain remaining=%0d required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_sched.md
# alu_issue_sched

Issue scheduler that shares a small pool of `NUM_ALU` ALUs among `NUM_REQ` ALU reservation-station entries. Each cycle it grants up to `NUM_ALU` ready entries round-robin and binds each grant to a free ALU. It records which entry owns each ALU until that ALU reports completion, then returns a completion pulse to the owning entry so the entry can broadcast on the CDB and free itself. It sits between `alu_rs` entry state and the shared `alu` instances.

## Interface
Parameters:
- `NUM_REQ`, 8, number of RS entries (requesters); power of two ≥ 2.
- `NUM_ALU`, 2, number of shared ALUs; 1 ≤ `NUM_ALU` ≤ `NUM_REQ`.
- `IDX_W`, `$clog2(NUM_REQ)`, requester index width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  pipeline flush; synchronous, single-cycle.
- `req_i`  in  `NUM_REQ`  entry valid with both operands ready and not yet issued.
- `alu_busy_i`  in  `NUM_ALU`  ALU cannot accept a new op this cycle.
- `alu_done_i`  in  `NUM_ALU`  ALU result valid this cycle (its `ready`).
- `gnt_o`  out  `NUM_REQ`  entry granted this cycle; at most `NUM_ALU` bits set.
- `alu_start_o`  out  `NUM_ALU`  start pulse to each ALU (its `load_alu`).
- `alu_sel_o`  out  `NUM_ALU*IDX_W`  requester index routed to each ALU's operand mux.
- `inflight_o`  out  `NUM_REQ`  entry currently owns an ALU.
- `done_o`  out  `NUM_REQ`  one-cycle pulse: this entry's op completed.

## Operation
- **Owner table.** One `{valid, idx}` record per ALU.
  - `inflight_o[r]` = OR over ALUs of (`valid && idx==r`).
- **Eligible requesters.** `elig = req_i & ~inflight_o`.
- **Free ALUs.** ALU `k` is free when `!owner[k].valid && !alu_busy_i[k]`.
  - With the bypass feature (see Configuration), ALU `k` is also free when `owner[k].valid && alu_done_i[k] && !alu_busy_i[k]`.
- **Grant.**
  - Scan `elig` circularly starting at `rr_ptr`.
  - The first eligible entry goes to the lowest-index free ALU, the second to the next free ALU, and so on, until free ALUs or eligible entries run out.
  - For each grant: `gnt_o[r]=1`, `alu_start_o[k]=1`, `alu_sel_o[k]=r`.
- **Pointer.** `rr_ptr` ← (highest-order-in-scan granted index + 1) mod `NUM_REQ`. It is unchanged when nothing is granted.
- **Completion.**
  - On `alu_done_i[k]` with `owner[k].valid`: `owner[k].valid` ← 0 (unless re-granted the same cycle), and `done_o[owner[k].idx]` pulses the next cycle.
  - `alu_done_i[k]` with no valid owner is ignored.
- **Same-cycle re-grant.** A grant to ALU `k` in the same cycle as its done overwrites `owner[k]` with the new idx. `done_o` still pulses for the old idx.
- **Flush.**
  - In the flush cycle: `gnt_o`, `alu_start_o`, and next-cycle `done_o` are all forced 0.
  - At the edge: every `owner.valid` ← 0 and `rr_ptr` ← 0.
  - `alu_done_i` arriving after the flush is ignored (no owner).
- **Reset (`rst`=0).** Regardless of clock:
  - `owner.valid`=0, `rr_ptr`=0, `done_o`=0.
  - `inflight_o`=0, `gnt_o`=0, `alu_start_o`=0, `alu_sel_o`=0.

## Timing
- `gnt_o`, `alu_start_o`, and `alu_sel_o` are combinational from `req_i`, `alu_busy_i`, `alu_done_i`, and state (zero-latency issue).
- `owner` and `rr_ptr` update at the edge after a grant. `inflight_o` is registered-state-derived, so it rises the cycle after the grant.
- `done_o` is registered: it is high exactly one cycle after `alu_done_i`.
- The RS must drop `req_i[r]` by the cycle after `gnt_o[r]`. A held request is masked by `inflight_o` anyway.
- ALU issue throughput:
  - With bypass: one op per ALU per cycle for single-cycle ops.
  - Without bypass: one bubble cycle per ALU between ops.
- Reset deassertion is synchronized externally; the first grant is possible in the first cycle after `rst` rises.

## Configuration
- Macro `ALU_ISSUE_BYPASS_EN`.
- **Defined:** an ALU asserting `alu_done_i` counts as free in the same cycle (back-to-back issue).
- **Undefined:** an ALU becomes free only once `owner.valid` is 0, so each ALU has at least one idle cycle between ops. Logic depth from `alu_done_i` to `alu_start_o` is removed.

## Structure
- The shared `structs` package gains:
  - `alu_owner_t` (`valid`, `idx[IDX_W-1:0]`);
  - constant `NUM_SHARED_ALU` (default for `NUM_ALU`).
- Sub-module `rr_find_first`:
  - takes a request vector, a start pointer, and a mask;
  - returns found flag plus index.
- `alu_issue_sched` instantiates `rr_find_first` `NUM_ALU` times in a chain, each masking out indices already granted.

## Test plan
- Reset with `req_i`=8'hFF → all outputs 0. After release, cycle 1: `gnt_o`=8'h03, `alu_sel_o`={1,0}. Next cycle: `inflight_o`=8'h03, `rr_ptr`=2.
- Both ALUs held, `req_i`=8'hFF → granted set rotates 0-1, 2-3, 4-5, 6-7, 0-1 across successive done cycles (bypass on). No entry waits more than 4 grant rounds.
- `alu_done_i`=2'b01 while `owner[0].idx`=5 → `done_o`=8'h20 one cycle later. Bypass off: no `alu_start_o[0]` that cycle. Bypass on: `alu_start_o[0]`=1 when eligible work exists.
- `alu_busy_i`=2'b10, `req_i`=8'h30 → only ALU0 granted (entry 4). Entry 5 is granted the next cycle via ALU1 once `busy` clears.
- `flush` while both ALUs are owned and `alu_done_i`=2'b11 → `gnt_o`=0, `done_o` stays 0 next cycle, `inflight_o`=0, and `rr_ptr`=0.
- `alu_done_i` on an unowned ALU → `done_o` stays 0 and the state is unchanged.
